// File: rtl/ice_bus_slave_buffer_pkg.sv
// Shared constants, entry layout and arbitration state encoding
// for the ICE slave-bus outbound message buffer.
package ice_bus_slave_buffer_pkg;

   localparam int ICE_SL_ENTRY_W = 9;
   localparam int ICE_SL_EOM_BIT = 8;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_PEND    = 2'd1,
      ARB_GRANTED = 2'd2,
      ARB_RELEASE = 2'd3
   } arb_state_t;

   function automatic logic [ICE_SL_ENTRY_W-1:0] pack_entry(
      input logic       eom,
      input logic [7:0] data
   );
      return {eom, data};
   endfunction

endpackage

// File: rtl/ice_bus_slave_buffer_msg_ram.sv
// ice_msg_ram: simple dual-port 2^ADDR_WIDTH x 9 message RAM.
// Ports: clk, rst (async, clears read register only), we/waddr/wdata
// write port, raddr -> rdata registered read port (1-cycle latency).
module ice_msg_ram
   import ice_bus_slave_buffer_pkg::*;
#(
   parameter int ADDR_WIDTH = 9
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      we,
   input  logic [ADDR_WIDTH-1:0]     waddr,
   input  logic [ICE_SL_ENTRY_W-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0]     raddr,
   output logic [ICE_SL_ENTRY_W-1:0] rdata
);

   logic [ICE_SL_ENTRY_W-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/ice_bus_slave_buffer.sv
// ice_bus_slave_buffer: device-side outbound message ring for the ICE slave bus.
// Ports: clk, rst (async high); wr_char/wr_char_valid/wr_char_last/wr_abort
// from local logic; sl_addr in, sl_data/sl_tail/sl_arb_request/sl_overflow out,
// sl_latch_tail/sl_arb_grant in, toward ice_bus_controller.
module ice_bus_slave_buffer
   import ice_bus_slave_buffer_pkg::*;
#(
   parameter int ADDR_WIDTH = 9
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [7:0]                wr_char,
   input  logic                      wr_char_valid,
   input  logic                      wr_char_last,
   input  logic                      wr_abort,
   input  logic [ADDR_WIDTH-1:0]     sl_addr,
   output logic [ICE_SL_ENTRY_W-1:0] sl_data,
   output logic [ADDR_WIDTH-1:0]     sl_tail,
   input  logic                      sl_latch_tail,
   output logic                      sl_arb_request,
   input  logic                      sl_arb_grant,
   output logic                      sl_overflow
);

   localparam logic [ADDR_WIDTH-1:0] ONE = 1;

   logic [ADDR_WIDTH-1:0] tail;
   logic [ADDR_WIDTH-1:0] head;
   logic [ADDR_WIDTH-1:0] wp;
   logic [ADDR_WIDTH-1:0] msg_cnt;
   logic [ADDR_WIDTH-1:0] wp_inc;
   logic                  drop;
   logic                  full;
   logic                  we;
   logic                  commit;
   logic                  latch;
   arb_state_t            state;
   arb_state_t            state_nxt;

   assign wp_inc = wp + ONE;
   // One slot stays empty so wp == tail always means empty.
   assign full   = (wp_inc == tail);
   assign we     = wr_char_valid & ~full & ~drop & ~wr_abort;
   assign commit = we & wr_char_last;
   assign latch  = sl_latch_tail & (state == ARB_GRANTED);

   assign sl_tail = tail;

   ice_msg_ram #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .waddr (wp),
      .wdata (pack_entry(wr_char_last, wr_char)),
      .raddr (sl_addr),
      .rdata (sl_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tail        <= '0;
         head        <= '0;
         wp          <= '0;
         msg_cnt     <= '0;
         drop        <= 1'b0;
         sl_overflow <= 1'b0;
      end else begin
         sl_overflow <= 1'b0;
         if (wr_abort) begin
            wp   <= head;
            drop <= 1'b0;
         end else if (wr_char_valid) begin
            if (drop) begin
               // Swallow the rest of the rejected message.
               if (wr_char_last) begin
                  drop <= 1'b0;
               end
            end else if (full) begin
               wp          <= head;
               sl_overflow <= 1'b1;
               drop        <= ~wr_char_last;
            end else begin
               wp <= wp_inc;
               if (wr_char_last) begin
                  head <= wp_inc;
               end
            end
         end
         if (latch) begin
            tail <= sl_addr;
         end
         unique case ({commit, latch})
            2'b10:   msg_cnt <= msg_cnt + ONE;
            2'b01:   msg_cnt <= msg_cnt - ONE;
            default: msg_cnt <= msg_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      sl_arb_request = 1'b0;
      unique case (state)
         ARB_IDLE: begin
            if (msg_cnt != '0) begin
               state_nxt = ARB_PEND;
            end
         end
         ARB_PEND: begin
            sl_arb_request = 1'b1;
            if (sl_arb_grant) begin
               state_nxt = ARB_GRANTED;
            end
         end
         ARB_GRANTED: begin
            sl_arb_request = 1'b1;
            if (sl_latch_tail) begin
               state_nxt = ARB_RELEASE;
            end else if (!sl_arb_grant) begin
               state_nxt = ARB_PEND;
            end
         end
         ARB_RELEASE: begin
            // Single low cycle drops the grant; a queued message
            // re-arbitrates straight away.
            if (msg_cnt != '0) begin
               state_nxt = ARB_PEND;
            end else begin
               state_nxt = ARB_IDLE;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

endmodule
